// File: rtl/vga_scanout.sv
// VGA 640x480@60 refresh engine: scans a 320x200 RGB332 framebuffer out of VRAM,
// doubling every byte into a 2x2 block with 40-line black borders top and bottom.
module vga_scanout #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned HS_START = 656,
  parameter int unsigned HS_END   = 752,
  parameter int unsigned VS_START = 490,
  parameter int unsigned VS_END   = 492,
  parameter int unsigned V_TOP    = 40
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int unsigned CW    = 10;
  localparam int unsigned AW    = 16;
  localparam int unsigned H_ACT = 640;
  localparam int unsigned V_ACT = 400;

  logic          pix_en;
  logic [CW-1:0] h;
  logic [CW-1:0] v;
  logic          last_h_c;
  logic          last_v_c;
  logic          active_c;
  logic          hs_c;
  logic          vs_c;
  logic [CW-1:0] v_rel_c;
  logic [AW-1:0] x_c;
  logic [AW-1:0] y_c;
  logic [AW-1:0] addr_c;
  logic          active_d1;
  logic          hs_d1;
  logic          vs_d1;
  logic          wrap_q;

  // Pixel-rate enable and raster counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_en <= 1'b0;
      h      <= '0;
      v      <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (last_h_c) begin
          h <= '0;
          v <= last_v_c ? '0 : v + CW'(1);
        end else begin
          h <= h + CW'(1);
        end
      end
    end
  end

  // Raster decode and framebuffer address: y*320 + x as two shifts
  always_comb begin
    last_h_c = (h == CW'(H_TOTAL - 1));
    last_v_c = (v == CW'(V_TOTAL - 1));
    active_c = (h < CW'(H_ACT)) && (v >= CW'(V_TOP)) && (v < CW'(V_TOP + V_ACT));
    hs_c     = !((h >= CW'(HS_START)) && (h < CW'(HS_END)));
    vs_c     = !((v >= CW'(VS_START)) && (v < CW'(VS_END)));
    v_rel_c  = v - CW'(V_TOP);
    x_c      = AW'(h >> 1);
    y_c      = AW'(v_rel_c >> 1);
    addr_c   = (y_c << 8) + (y_c << 6) + x_c;
  end

  // Stage 1: VRAM address plus delayed qualifiers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_addr <= '0;
      active_d1 <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
    end else if (pix_en) begin
      vram_addr <= active_c ? addr_c : '0;
      active_d1 <= active_c;
      hs_d1     <= hs_c;
      vs_d1     <= vs_c;
    end
  end

  // Stage 2: colour decode with border blanking, syncs kept aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else if (pix_en) begin
      vga_r  <= active_d1 ? vram_data[7:5] : '0;
      vga_g  <= active_d1 ? vram_data[4:2] : '0;
      vga_b  <= active_d1 ? vram_data[1:0] : '0;
      vga_hs <= hs_d1;
      vga_vs <= vs_d1;
    end
  end

  // Frame pulse lands one clk after the counters wrap to (0,0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      wrap_q      <= pix_en & last_h_c & last_v_c;
      frame_start <= wrap_q;
    end
  end

endmodule
